// File: rtl/toggle_sync_pkg.sv
// Shared types and default sizing for the toggle-handshake source side.
package toggle_sync_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 1023;

  // Bits needed to count 0..timeout, never narrower than one bit.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ack_sync_chain.sv
// Multi-flop synchronizer bringing the destination ack toggle into clk.
module ack_sync_chain
  import toggle_sync_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_next[gi] = d;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/toggle_sync_src.sv
// Source side of a toggle handshake: latches one payload, flips req_tgl,
// and waits for the synchronized ack toggle to match before accepting again.
module toggle_sync_src
  import toggle_sync_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             req_tgl,
  output logic [WIDTH-1:0] req_data,
  input  logic             ack_tgl,
  output logic             busy,
  output logic             timeout_err,
  output logic             proto_err,
  input  logic             err_clr
);

  localparam int TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  state_t            state_reg, state_next;
  logic              req_tgl_reg, req_tgl_next;
  logic [WIDTH-1:0]  req_data_reg, req_data_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [TW-1:0]     timer_inc;
  logic              timeout_err_reg, timeout_err_next;
  logic              proto_err_reg, proto_err_next;
  logic              timeout_set, proto_set;
  logic              ack_sync;

  ack_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (ack_tgl),
    .q  (ack_sync)
  );

  assign timer_inc = timer_reg + TW'(1);

  always_comb begin
    state_next    = state_reg;
    req_tgl_next  = req_tgl_reg;
    req_data_next = req_data_reg;
    timer_next    = timer_reg;
    timeout_set   = 1'b0;
    proto_set     = 1'b0;
    case (state_reg)
      IDLE: begin
        // An ack edge with nothing outstanding means the far side is out of step.
        if (ack_sync != req_tgl_reg) begin
          proto_set = 1'b1;
        end
        if (in_valid) begin
          req_data_next = in_data;
          req_tgl_next  = ~req_tgl_reg;
          timer_next    = '0;
          state_next    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Timer saturates; the flag is raised on the edge it first reaches TIMEOUT.
        if (TIMEOUT_EN && (timer_reg != TIMEOUT_VAL)) begin
          timer_next = timer_inc;
          if (timer_inc == TIMEOUT_VAL) begin
            timeout_set = 1'b1;
          end
        end
        if (ack_sync == req_tgl_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    timeout_err_next = timeout_err_reg;
    proto_err_next   = proto_err_reg;
    if (err_clr) begin
      timeout_err_next = 1'b0;
      proto_err_next   = 1'b0;
    end
    if (timeout_set) begin
      timeout_err_next = 1'b1;
    end
    if (proto_set) begin
      proto_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      req_tgl_reg     <= 1'b0;
      req_data_reg    <= '0;
      timer_reg       <= '0;
      timeout_err_reg <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      req_tgl_reg     <= req_tgl_next;
      req_data_reg    <= req_data_next;
      timer_reg       <= timer_next;
      timeout_err_reg <= timeout_err_next;
      proto_err_reg   <= proto_err_next;
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign busy        = (state_reg == WAIT_ACK);
  assign req_tgl     = req_tgl_reg;
  assign req_data    = req_data_reg;
  assign timeout_err = timeout_err_reg;
  assign proto_err   = proto_err_reg;

endmodule

// File: tb/tb_toggle_sync_src.sv
// Directed bench for toggle_sync_src with a payload/toggle scoreboard.
module tb_toggle_sync_src;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         req_tgl;
  logic [W-1:0] req_data;
  logic         ack_tgl;
  logic         busy;
  logic         timeout_err;
  logic         proto_err;
  logic         err_clr = 1'b0;

  logic ack_manual = 1'b0;
  logic ack_auto   = 1'b0;
  logic ack_model  = 1'b0;
  int   ack_cnt    = 0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic         tgl;
    logic [W-1:0] data;
  } exp_t;
  exp_t sb[$];

  logic         exp_tgl  = 1'b0;
  logic         mon_tgl  = 1'b0;
  logic [W-1:0] mon_data = '0;

  assign ack_tgl = ack_auto ? ack_model : ack_manual;

  toggle_sync_src #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .req_tgl(req_tgl),
    .req_data(req_data),
    .ack_tgl(ack_tgl),
    .busy(busy),
    .timeout_err(timeout_err),
    .proto_err(proto_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    exp_tgl  = ~exp_tgl;
    e.tgl    = exp_tgl;
    e.data   = d;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    $display("send data=%02h tgl=%0b", d, exp_tgl);
  endtask

  task automatic wait_ready(input string tag, input int max);
    int n;
    n = 0;
    while (!in_ready && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(in_ready), 32'd1);
  endtask

  // Destination stand-in: echoes req_tgl back after a fixed latency.
  always @(posedge clk) begin
    if (!ack_auto) begin
      ack_model <= ack_manual;
      ack_cnt   <= 0;
    end else if (req_tgl !== ack_model) begin
      if (ack_cnt == 3) begin
        ack_model <= req_tgl;
        ack_cnt   <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  // Scoreboard: each req_tgl flip must carry the next expected payload/toggle.
  always @(negedge clk) begin
    if (rst) begin
      mon_tgl  <= 1'b0;
      mon_data <= '0;
    end else if (req_tgl !== mon_tgl) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("req_tgl", 32'(req_tgl), 32'(e.tgl));
        chk("req_data", 32'(req_data), 32'(e.data));
        $display("xfer req_tgl=%0b req_data=%02h", req_tgl, req_data);
      end
      mon_tgl  <= req_tgl;
      mon_data <= req_data;
    end else if (busy) begin
      chk("data_hold", 32'(req_data), 32'(mon_data));
    end
  end

  initial begin
    // Reset state, observed before any clock edge.
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_tgl", 32'(req_tgl), 32'd0);
    chk("rst_req_data", 32'(req_data), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic transfer, ack 5 cycles later, ready 3 edges after ack sampled.
    send(8'hA5);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h11;
    repeat (5) tick();
    ack_manual = 1'b1;
    tick();
    chk("basic_lat1", 32'(in_ready), 32'd0);
    tick();
    chk("basic_lat2", 32'(in_ready), 32'd0);
    tick();
    chk("basic_lat3", 32'(in_ready), 32'd1);
    chk("basic_proto", 32'(proto_err), 32'd0);
    chk("basic_timeout", 32'(timeout_err), 32'd0);

    // Reset both sides between scenarios.
    rst = 1'b1;
    ack_manual = 1'b0;
    exp_tgl = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back transfers with in_valid held high and an auto ack.
    ack_auto = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_t e;
      wait_ready("b2b_ready", 30);
      in_data = 8'(i);
      exp_tgl = ~exp_tgl;
      e.tgl   = exp_tgl;
      e.data  = 8'(i);
      sb.push_back(e);
      tick();
      $display("b2b data=%02h tgl=%0b", 8'(i), exp_tgl);
      chk("b2b_busy", 32'(busy), 32'd1);
      in_data = 8'hEE;
    end
    in_valid = 1'b0;
    wait_ready("b2b_done", 30);
    chk("b2b_tgl_final", 32'(req_tgl), 32'd1);
    chk("b2b_proto", 32'(proto_err), 32'd0);
    chk("b2b_timeout", 32'(timeout_err), 32'd0);

    // Timeout: ack withheld, flag on the 16th WAIT_ACK edge, no abort.
    ack_manual = 1'b1;
    tick();
    ack_auto = 1'b0;
    tick();
    send(8'h5A);
    repeat (15) tick();
    chk("to_before", 32'(timeout_err), 32'd0);
    tick();
    chk("to_set", 32'(timeout_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    chk("to_still_busy", 32'(busy), 32'd1);
    ack_manual = 1'b0;
    tick();
    tick();
    chk("to_ack_lat2", 32'(busy), 32'd1);
    tick();
    chk("to_ack_done", 32'(in_ready), 32'd1);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr", 32'(timeout_err), 32'd0);

    // Protocol error: ack toggles while IDLE.
    ack_manual = 1'b1;
    tick();
    tick();
    chk("pe_before", 32'(proto_err), 32'd0);
    tick();
    chk("pe_set", 32'(proto_err), 32'd1);
    chk("pe_in_ready", 32'(in_ready), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("pe_set_wins", 32'(proto_err), 32'd1);
    send(8'h3C);
    chk("pe_xfer_busy", 32'(busy), 32'd1);
    tick();
    chk("pe_xfer_done", 32'(in_ready), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("pe_clr", 32'(proto_err), 32'd0);

    // Normal transfer to leave req_tgl at 0 before the reset scenario.
    send(8'h77);
    tick();
    ack_manual = 1'b0;
    wait_ready("n77_done", 10);
    chk("n77_proto", 32'(proto_err), 32'd0);

    // Asynchronous reset in WAIT_ACK, checked between clock edges.
    send(8'hC3);
    tick();
    chk("ar_busy", 32'(busy), 32'd1);
    chk("ar_tgl_pre", 32'(req_tgl), 32'd1);
    #2;
    rst = 1'b1;
    ack_manual = 1'b0;
    exp_tgl = 1'b0;
    #1;
    chk("ar_req_tgl", 32'(req_tgl), 32'd0);
    chk("ar_req_data", 32'(req_data), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_busy_low", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("ar_after_ready", 32'(in_ready), 32'd1);
    chk("ar_after_proto", 32'(proto_err), 32'd0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
